// File: rtl/ram_latency_ctrl.sv
// ram_latency_ctrl: word-addressed backing memory behind the core's ram_if.
// A request is accepted from FREE, held in BUSY for LAT cycles, committed on
// the BUSY->ACCESS edge, and the controller then returns to FREE. ERROR covers
// conflicting requests and out-of-range word indices.
module ram_latency_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned LAT    = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] memaddr,
  input  logic [DATA_W-1:0] memstore,
  input  logic              memREN,
  input  logic              memWEN,
  output logic [DATA_W-1:0] ramload,
  output logic [1:0]        ramstate
);

  localparam int unsigned IDX_W    = ADDR_W - 2;
  localparam int unsigned MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT = 4'(LAT - 1);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  addr_q;
  logic              op_q;      // 1 = write, 0 = read
  logic [DATA_W-1:0] data_q;
  logic [3:0]        cnt;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic [MEM_AW-1:0] mem_idx;
  logic              in_range;
  logic              req_one;
  logic              req_both;
  logic              req_match;
  logic              mem_we;
  logic              unused_low_bits;

  assign idx             = memaddr[ADDR_W-1:2];
  assign mem_idx         = addr_q[MEM_AW-1:0];
  assign unused_low_bits = ^memaddr[1:0];

  // DEPTH is a power of two, so the index is legal exactly when no bit at or
  // above log2(DEPTH) is set; this avoids truncating DEPTH to IDX_W bits.
  assign in_range = ((idx >> MEM_AW) == '0);

  assign req_one  = memREN ^ memWEN;
  assign req_both = memREN & memWEN;

  // The requestor must keep the same operation and word address for the whole
  // BUSY phase; any deviation aborts the access.
  assign req_match = (memWEN == op_q) && (memREN == !op_q) && (idx == addr_q);

  assign mem_we = !RST && (state == BUSY) && req_match && (cnt == '0) && op_q;

  assign ramstate = state;

  // Control FSM with request latch, latency counter and registered read data.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= FREE;
      addr_q  <= '0;
      op_q    <= 1'b0;
      data_q  <= '0;
      cnt     <= '0;
      ramload <= '0;
    end else begin
      case (state)
        FREE: begin
          if (req_both) begin
            state <= ERROR;
          end else if (req_one) begin
            if (in_range) begin
              addr_q <= idx;
              op_q   <= memWEN;
              data_q <= memstore;
              cnt    <= CNT_INIT;
              state  <= BUSY;
            end else begin
              state <= ERROR;
            end
          end
        end
        BUSY: begin
          if (!req_match) begin
            state <= FREE;
          end else if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= ACCESS;
            if (!op_q) begin
              ramload <= mem[mem_idx];
            end
          end
        end
        ACCESS:  state <= FREE;
        ERROR:   state <= FREE;
        default: state <= FREE;
      endcase
    end
  end

  // Storage array; deliberately not reset so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_idx] <= data_q;
    end
  end

endmodule

// File: tb/tb_ram_latency_ctrl.sv
// Bench for ram_latency_ctrl: three instances (LAT=2, LAT=1, LAT=15) driven
// by a table of directed transactions plus hand-written corner sequences.
module tb_ram_latency_ctrl;

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_ERROR  = 2'd3;

  logic        clk;
  logic        rst;
  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic        ren  [3];
  logic        wen  [3];
  logic [31:0] ld   [3];
  logic [1:0]  st   [3];

  int checks;
  int failures;

  ram_latency_ctrl #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .LAT(2)) u_lat2 (
    .CLK(clk), .RST(rst), .memaddr(addr[0]), .memstore(wdat[0]),
    .memREN(ren[0]), .memWEN(wen[0]), .ramload(ld[0]), .ramstate(st[0])
  );

  ram_latency_ctrl #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .LAT(1)) u_lat1 (
    .CLK(clk), .RST(rst), .memaddr(addr[1]), .memstore(wdat[1]),
    .memREN(ren[1]), .memWEN(wen[1]), .ramload(ld[1]), .ramstate(st[1])
  );

  ram_latency_ctrl #(.ADDR_W(32), .DATA_W(32), .DEPTH(1024), .LAT(15)) u_lat15 (
    .CLK(clk), .RST(rst), .memaddr(addr[2]), .memstore(wdat[2]),
    .memREN(ren[2]), .memWEN(wen[2]), .ramload(ld[2]), .ramstate(st[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one request, hold it until ACCESS/ERROR, then release it.
  task automatic run_txn(input int i, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         output int nbusy, output logic [1:0] fin,
                         output logic [31:0] load, output logic [1:0] after);
    @(negedge clk);
    ren[i] = r; wen[i] = w; addr[i] = a; wdat[i] = d;
    nbusy = 0;
    fin   = S_FREE;
    load  = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (st[i] == S_BUSY) begin
        nbusy++;
      end else begin
        fin  = st[i];
        load = ld[i];
        break;
      end
    end
    ren[i] = 1'b0; wen[i] = 1'b0;
    @(negedge clk);
    after = st[i];
  endtask

  typedef struct {
    logic        r;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  fin;
    int          busy;
    logic        chk_load;
    logic [31:0] load;
  } vec_t;

  vec_t vecs [12];

  logic [31:0] model [int];
  int          keys  [$];

  initial begin
    int          nb;
    logic [1:0]  fin;
    logic [1:0]  after;
    logic [31:0] load;
    int          n;

    checks   = 0;
    failures = 0;

    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, S_ACCESS, 2, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         S_ACCESS, 2, 1'b1, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         S_ACCESS, 2, 1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0040, 32'hAAAA_AAAA, S_ACCESS, 2, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 32'h0000_0010, 32'h1111_1111, S_ERROR,  0, 1'b0, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         S_ACCESS, 2, 1'b1, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h5555_5555, S_ERROR,  0, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h0BAD_F00D, S_ACCESS, 2, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         S_ACCESS, 2, 1'b1, 32'h0BAD_F00D};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         S_ERROR,  0, 1'b1, 32'h0BAD_F00D};
    vecs[10] = '{1'b0, 1'b1, 32'h7FFF_FFFC, 32'h6666_6666, S_ERROR,  0, 1'b0, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         S_ACCESS, 2, 1'b1, 32'hAAAA_AAAA};

    for (int i = 0; i < 3; i++) begin
      addr[i] = '0; wdat[i] = '0; ren[i] = 1'b0; wen[i] = 1'b0;
    end

    // Reset state and idle
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_state[%0d]", i), 32'(st[i]), 32'(S_FREE));
      check($sformatf("reset_load[%0d]", i), ld[i], 32'h0);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_state", 32'(st[0]), 32'(S_FREE));

    // Directed vector table on the LAT=2 instance
    for (int v = 0; v < 12; v++) begin
      run_txn(0, vecs[v].r, vecs[v].w, vecs[v].a, vecs[v].d, nb, fin, load, after);
      check($sformatf("vec%0d_final", v), 32'(fin), 32'(vecs[v].fin));
      check($sformatf("vec%0d_busy", v), 32'(nb), 32'(vecs[v].busy));
      if (vecs[v].chk_load) check($sformatf("vec%0d_load", v), load, vecs[v].load);
      check($sformatf("vec%0d_free", v), 32'(after), 32'(S_FREE));
    end

    // Asynchronous reset in the middle of a cycle
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_state", 32'(st[0]), 32'(S_FREE));
    check("async_rst_load", ld[0], 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Abort by address change during BUSY, then re-acceptance
    run_txn(0, 1'b0, 1'b1, 32'h20, 32'h1111_2222, nb, fin, load, after);
    check("abort_pre_w20", 32'(fin), 32'(S_ACCESS));
    run_txn(0, 1'b0, 1'b1, 32'h24, 32'h3333_4444, nb, fin, load, after);
    check("abort_pre_w24", 32'(fin), 32'(S_ACCESS));
    run_txn(0, 1'b1, 1'b0, 32'h10, 32'h0, nb, fin, load, after);
    check("abort_pre_load", load, 32'hDEAD_BEEF);
    @(negedge clk);
    ren[0] = 1'b1; addr[0] = 32'h20;
    @(negedge clk);
    check("abort_busy", 32'(st[0]), 32'(S_BUSY));
    addr[0] = 32'h24;
    @(negedge clk);
    check("abort_free", 32'(st[0]), 32'(S_FREE));
    check("abort_load_kept", ld[0], 32'hDEAD_BEEF);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n++;
      if (st[0] == S_ACCESS) break;
    end
    check("reaccept_edges", 32'(n), 32'd3);
    check("reaccept_load", ld[0], 32'h3333_4444);
    ren[0] = 1'b0;
    @(negedge clk);
    check("reaccept_free", 32'(st[0]), 32'(S_FREE));

    // memstore changes during BUSY must not affect the written word
    @(negedge clk);
    wen[0] = 1'b1; addr[0] = 32'h50; wdat[0] = 32'hCAFE_F00D;
    @(negedge clk);
    wdat[0] = 32'h0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (st[0] == S_ACCESS) break;
      @(negedge clk);
      n++;
    end
    check("late_data_access", 32'(st[0]), 32'(S_ACCESS));
    wen[0] = 1'b0;
    run_txn(0, 1'b1, 1'b0, 32'h50, 32'h0, nb, fin, load, after);
    check("late_data_load", load, 32'hCAFE_F00D);

    // Reset during a pending write leaves the old word intact
    @(negedge clk);
    wen[0] = 1'b1; addr[0] = 32'h40; wdat[0] = 32'h1234_5678;
    @(negedge clk);
    check("rst_write_busy", 32'(st[0]), 32'(S_BUSY));
    #2 rst = 1'b1;
    #1;
    check("rst_write_state", 32'(st[0]), 32'(S_FREE));
    wen[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_txn(0, 1'b1, 1'b0, 32'h40, 32'h0, nb, fin, load, after);
    check("rst_write_kept", load, 32'hAAAA_AAAA);

    // Latency sweep on LAT=1 and LAT=15
    run_txn(1, 1'b0, 1'b1, 32'h100, 32'hA1A1_0001, nb, fin, load, after);
    check("lat1_w_busy", 32'(nb), 32'd1);
    check("lat1_w_final", 32'(fin), 32'(S_ACCESS));
    run_txn(1, 1'b1, 1'b0, 32'h100, 32'h0, nb, fin, load, after);
    check("lat1_r_busy", 32'(nb), 32'd1);
    check("lat1_r_load", load, 32'hA1A1_0001);
    run_txn(1, 1'b0, 1'b1, 32'hFFC, 32'hA1A1_0FFC, nb, fin, load, after);
    run_txn(1, 1'b1, 1'b0, 32'hFFC, 32'h0, nb, fin, load, after);
    check("lat1_top_load", load, 32'hA1A1_0FFC);
    run_txn(2, 1'b0, 1'b1, 32'h200, 32'hF15F_0002, nb, fin, load, after);
    check("lat15_w_busy", 32'(nb), 32'd15);
    check("lat15_w_final", 32'(fin), 32'(S_ACCESS));
    run_txn(2, 1'b1, 1'b0, 32'h200, 32'h0, nb, fin, load, after);
    check("lat15_r_busy", 32'(nb), 32'd15);
    check("lat15_r_load", load, 32'hF15F_0002);
    check("lat15_r_free", 32'(after), 32'(S_FREE));

    // Random write/read pairs against a reference array
    for (int p = 0; p < 100; p++) begin
      int          wa;
      logic [31:0] wd;
      int          ra;
      wa = 32'h800 + 4 * int'($urandom_range(0, 255));
      wd = $urandom;
      run_txn(0, 1'b0, 1'b1, 32'(wa), wd, nb, fin, load, after);
      check($sformatf("rand%0d_w", p), 32'(fin), 32'(S_ACCESS));
      if (!model.exists(wa)) keys.push_back(wa);
      model[wa] = wd;
      ra = keys[$urandom_range(0, keys.size() - 1)];
      run_txn(0, 1'b1, 1'b0, 32'(ra) + 32'($urandom_range(0, 3)), 32'h0, nb, fin, load, after);
      check($sformatf("rand%0d_r", p), load, model[ra]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
